// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts the 0x55 0xAA header in a serial byte stream, buffers the payload,
// verifies the 8-bit sum over length and payload, then replays an accepted payload as one
// gap-free valid burst followed by an enforced idle gap.
module serial_frame_rx #(
  parameter int unsigned MAX_PAYLOAD    = 256,
  parameter int unsigned MIN_PAYLOAD    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        rx_byte_vld_i,
  input  logic [7:0]  rx_byte_i,
  output logic        slave_rx_data_vld_o,
  output logic [7:0]  slave_rx_data_o,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [2:0]  err_code_o,
  output logic [15:0] frame_ok_cnt_o,
  output logic [15:0] frame_err_cnt_o
);

  localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] S_HUNT0  = 3'd0;
  localparam logic [2:0] S_HUNT1  = 3'd1;
  localparam logic [2:0] S_LENH   = 3'd2;
  localparam logic [2:0] S_LENL   = 3'd3;
  localparam logic [2:0] S_PAY    = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_REPLAY = 3'd6;
  localparam logic [2:0] S_GAP    = 3'd7;

  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CSUM = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;
  localparam logic [2:0] ERR_OVR  = 3'd4;

  logic [2:0]    r_state;
  logic [7:0]    r_len_h;
  logic [15:0]   r_len;
  logic [15:0]   r_cnt;      // bytes remaining in the current payload or replay
  logic [7:0]    r_sum;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [TW-1:0] r_tmo_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_vld;
  logic [7:0]    r_data;
  logic          r_ok;
  logic          r_err;
  logic [2:0]    r_err_code;
  logic [15:0]   r_ok_cnt;
  logic [15:0]   r_err_cnt;
  logic [7:0]    r_mem [MAX_PAYLOAD];

  logic [15:0]   w_len;
  logic          w_len_ok;
  logic          w_tmo_run;
  logic          w_tmo_hit;
  logic          w_ok;
  logic          w_err;
  logic [2:0]    w_err_code;

  assign slave_rx_data_vld_o = r_vld;
  assign slave_rx_data_o     = r_data;
  assign frame_ok_o          = r_ok;
  assign frame_err_o         = r_err;
  assign err_code_o          = r_err_code;
  assign frame_ok_cnt_o      = r_ok_cnt;
  assign frame_err_cnt_o     = r_err_cnt;

  // Decode length, idle timeout and the accept/error event for this cycle.
  always_comb begin
    w_len      = {r_len_h, rx_byte_i};
    w_len_ok   = (32'(w_len) >= MIN_PAYLOAD) && (32'(w_len) <= MAX_PAYLOAD);
    w_tmo_run  = (r_state == S_HUNT1) || (r_state == S_LENH) || (r_state == S_LENL) ||
                 (r_state == S_PAY) || (r_state == S_CSUM);
    // A strobe in the expiry cycle wins over the timeout.
    w_tmo_hit  = w_tmo_run && !rx_byte_vld_i && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    w_ok       = 1'b0;
    w_err      = 1'b0;
    w_err_code = 3'd0;
    if (w_tmo_hit) begin
      w_err      = 1'b1;
      w_err_code = ERR_TMO;
    end else if (rx_byte_vld_i) begin
      case (r_state)
        S_LENL: begin
          if (!w_len_ok) begin
            w_err      = 1'b1;
            w_err_code = ERR_LEN;
          end
        end
        S_CSUM: begin
          if (rx_byte_i != r_sum) begin
            w_err      = 1'b1;
            w_err_code = ERR_CSUM;
          end else begin
            w_ok = 1'b1;
          end
        end
        S_REPLAY, S_GAP: begin
          w_err      = 1'b1;
          w_err_code = ERR_OVR;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk_sys_i) begin
    if ((r_state == S_PAY) && rx_byte_vld_i) begin
      r_mem[r_wr_ptr] <= rx_byte_i;
    end
  end

  // Frame FSM, replay datapath, status pulses and counters.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state    <= S_HUNT0;
      r_len_h    <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tmo_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_vld      <= 1'b0;
      r_data     <= '0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
      r_ok_cnt   <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_vld <= 1'b0;
      r_ok  <= w_ok;
      r_err <= w_err;
      if (w_ok) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (w_err) begin
        r_err_code <= w_err_code;
        r_err_cnt  <= r_err_cnt + 16'd1;
      end

      if (w_tmo_run && !rx_byte_vld_i && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_tmo_hit) begin
        r_state <= S_HUNT0;
      end else begin
        case (r_state)
          S_HUNT0: begin
            if (rx_byte_vld_i && (rx_byte_i == 8'h55)) r_state <= S_HUNT1;
          end
          S_HUNT1: begin
            if (rx_byte_vld_i) begin
              if (rx_byte_i == 8'hAA) r_state <= S_LENH;
              else if (rx_byte_i != 8'h55) r_state <= S_HUNT0;
            end
          end
          S_LENH: begin
            if (rx_byte_vld_i) begin
              r_len_h <= rx_byte_i;
              r_sum   <= rx_byte_i;
              r_state <= S_LENL;
            end
          end
          S_LENL: begin
            if (rx_byte_vld_i) begin
              r_sum    <= r_sum + rx_byte_i;
              r_len    <= w_len;
              r_cnt    <= w_len;
              r_wr_ptr <= '0;
              r_state  <= w_len_ok ? S_PAY : S_HUNT0;
            end
          end
          S_PAY: begin
            if (rx_byte_vld_i) begin
              r_sum    <= r_sum + rx_byte_i;
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_cnt    <= r_cnt - 16'd1;
              if (r_cnt == 16'd1) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_byte_vld_i) begin
              r_rd_ptr <= '0;
              r_cnt    <= r_len;
              r_state  <= w_ok ? S_REPLAY : S_HUNT0;
            end
          end
          S_REPLAY: begin
            // The memory read lands straight in the output register, giving the 1-cycle latency.
            r_vld    <= 1'b1;
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt    <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
          default: begin
            // First GAP cycle still shows the last burst byte, so stay one extra cycle.
            if (r_gap_cnt == GW'(GAP_CYCLES)) r_state <= S_HUNT0;
            else r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx.
module tb_serial_frame_rx;

  localparam int unsigned MAXP = 256;
  localparam int unsigned MINP = 2;
  localparam int unsigned TO   = 40;
  localparam int unsigned GAP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_vld;
  logic [7:0]  rx_byte;
  logic        vld;
  logic [7:0]  data;
  logic        ok;
  logic        err;
  logic [2:0]  code;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_ok = 0;
  int exp_err = 0;
  int rises = 0;
  logic prev_vld = 1'b0;
  logic [7:0] pay[$];

  serial_frame_rx #(
    .MAX_PAYLOAD   (MAXP),
    .MIN_PAYLOAD   (MINP),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk_sys_i          (clk),
    .rst_i              (rst),
    .rx_byte_vld_i      (rx_vld),
    .rx_byte_i          (rx_byte),
    .slave_rx_data_vld_o(vld),
    .slave_rx_data_o    (data),
    .frame_ok_o         (ok),
    .frame_err_o        (err),
    .err_code_o         (code),
    .frame_ok_cnt_o     (ok_cnt),
    .frame_err_cnt_o    (err_cnt)
  );

  always #5 clk = ~clk;

  // Count rising edges of the burst valid.
  always @(negedge clk) begin
    prev_vld <= vld;
    if (vld === 1'b1 && prev_vld !== 1'b1) rises <= rises + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_byte = b;
    tick();
    rx_vld  = 1'b0;
  endtask

  function automatic logic [7:0] calc_cs(input logic [7:0] lh, input logic [7:0] ll);
    logic [7:0] s;
    s = lh + ll;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] cs);
    logic [15:0] n;
    n = 16'(pay.size());
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (pay[i]) send_byte(pay[i]);
    send_byte(cs);
  endtask

  // Called right after the checksum strobe; optionally strobes an overrun byte at burst index ov.
  task automatic expect_burst(input string nm, input int ov);
    exp_ok++;
    checks++;
    if (ok !== 1'b1 || err !== 1'b0 || ok_cnt !== exp_ok[15:0])
      $display("FAIL %s accept: ok=%b err=%b cnt=%0d required ok=1 err=0 cnt=%0d",
               nm, ok, err, ok_cnt, exp_ok);
    if (ok !== 1'b1 || err !== 1'b0 || ok_cnt !== exp_ok[15:0]) errors++;
    checks++;
    if (vld !== 1'b0) begin
      errors++;
      $display("FAIL %s early_vld: vld=%b required 0", nm, vld);
    end
    for (int i = 0; i < pay.size(); i++) begin
      if (i == ov) begin
        rx_vld  = 1'b1;
        rx_byte = 8'hEE;
      end
      tick();
      rx_vld = 1'b0;
      checks++;
      if (vld !== 1'b1 || data !== pay[i] || (i == 0 && ok !== 1'b0)) begin
        errors++;
        $display("FAIL %s burst[%0d]: vld=%b data=%h ok=%b required vld=1 data=%h",
                 nm, i, vld, data, ok, pay[i]);
      end
      if (i == ov) begin
        exp_err++;
        checks++;
        if (err !== 1'b1 || code !== 3'd4 || err_cnt !== exp_err[15:0]) begin
          errors++;
          $display("FAIL %s overrun: err=%b code=%0d cnt=%0d required 1 4 %0d",
                   nm, err, code, err_cnt, exp_err);
        end
      end
    end
    for (int g = 0; g <= GAP; g++) begin
      tick();
      checks++;
      if (vld !== 1'b0) begin
        errors++;
        $display("FAIL %s gap[%0d]: vld=%b required 0", nm, g, vld);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_vld = 1'b0; rx_byte = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({vld, data, ok, err, code, ok_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: vld=%b data=%h ok=%b err=%b code=%0d okc=%0d errc=%0d required 0",
               vld, data, ok, err, code, ok_cnt, err_cnt);
    end
  endtask

  task automatic test_good_frame();
    pay = '{8'h10, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    // 06+10+00+12+34+56+78 = 0x12A
    send_frame(8'h2A);
    expect_burst("good", -1);
  endtask

  task automatic test_bad_checksum();
    int seen;
    pay = '{8'h10, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(8'h2B);
    exp_err++;
    checks++;
    if (err !== 1'b1 || ok !== 1'b0 || code !== 3'd2 || err_cnt !== exp_err[15:0]) begin
      errors++;
      $display("FAIL bad_cs: err=%b ok=%b code=%0d cnt=%0d required 1 0 2 %0d",
               err, ok, code, err_cnt, exp_err);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (vld !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL bad_cs_no_vld: vld cycles=%0d required 0", seen);
    end
    send_frame(8'h2A);
    expect_burst("after_bad", -1);
  endtask

  task automatic test_length();
    logic [15:0] lens [2];
    lens[0] = 16'h0001;
    lens[1] = 16'h0101;
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h55);
      send_byte(8'hAA);
      send_byte(lens[k][15:8]);
      send_byte(lens[k][7:0]);
      exp_err++;
      checks++;
      if (err !== 1'b1 || code !== 3'd1 || err_cnt !== exp_err[15:0]) begin
        errors++;
        $display("FAIL len_%h: err=%b code=%0d cnt=%0d required 1 1 %0d",
                 lens[k], err, code, err_cnt, exp_err);
      end
    end
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i * 7 + 3));
    send_frame(calc_cs(8'h01, 8'h00));
    expect_burst("len_max", -1);
  endtask

  task automatic test_timeout();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h00);
    repeat (TO - 1) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: err=%b required 0", err);
    end
    tick();
    exp_err++;
    checks++;
    if (err !== 1'b1 || code !== 3'd3 || err_cnt !== exp_err[15:0]) begin
      errors++;
      $display("FAIL tmo: err=%b code=%0d cnt=%0d required 1 3 %0d", err, code, err_cnt, exp_err);
    end
    send_byte(8'h12);
    send_byte(8'h55);
    pay = '{8'hAB, 8'hCD};
    // 00+02+AB+CD = 0x17A
    send_frame(8'h7A);
    expect_burst("resync", -1);
  endtask

  task automatic test_overrun();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(8'h2C);
    expect_burst("overrun", 3);
    checks++;
    if (code !== 3'd4) begin
      errors++;
      $display("FAIL code_held: code=%0d required 4", code);
    end
  endtask

  task automatic test_reset_replay();
    int seen;
    pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_frame(8'h8E);
    tick();
    checks++;
    if (vld !== 1'b1 || data !== 8'hA1) begin
      errors++;
      $display("FAIL rst_pre: vld=%b data=%h required 1 a1", vld, data);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    checks++;
    if ({vld, data, ok, err, code, ok_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_replay: vld=%b data=%h ok=%b err=%b code=%0d okc=%0d errc=%0d required 0",
               vld, data, ok, err, code, ok_cnt, err_cnt);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vld !== 1'b0 || err !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_quiet: active cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rises;
    pay = '{8'hC0, 8'h01};
    send_frame(8'hC3);
    expect_burst("b2b_first", -1);
    pay = '{8'hC1, 8'h02, 8'h03};
    send_frame(8'hC9);
    expect_burst("b2b_second", -1);
    checks++;
    if (rises - r0 != 2 || ok_cnt !== 16'd2) begin
      errors++;
      $display("FAIL b2b_bursts: rises=%0d okc=%0d required 2 2", rises - r0, ok_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_overrun();
    test_reset_replay();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
